// File: rtl/alu_scheduler_if.sv
// Bundle between the ALU scheduler, its two requesters and the shared ALU.
interface alu_scheduler_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned FUN_W  = 5;
   localparam int unsigned FLAG_W = 4;

   logic              req0_valid;
   logic              req0_ready;
   logic [FUN_W-1:0]  req0_funsel;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_use_carry;

   logic              req1_valid;
   logic              req1_ready;
   logic [FUN_W-1:0]  req1_funsel;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_use_carry;

   logic              rsp0_valid;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp_result;
   logic [FLAG_W-1:0] rsp_flags;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [FUN_W-1:0]  alu_funsel;
   logic              alu_cin;
   logic [DATA_W-1:0] alu_out;
   logic [FLAG_W-1:0] alu_flags;

   // Scheduler side
   modport slave (
      input  req0_valid, req0_funsel, req0_a, req0_b, req0_use_carry,
      input  req1_valid, req1_funsel, req1_a, req1_b, req1_use_carry,
      input  alu_out, alu_flags,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
      output alu_a, alu_b, alu_funsel, alu_cin
   );

   // Requester and ALU side
   modport master (
      output req0_valid, req0_funsel, req0_a, req0_b, req0_use_carry,
      output req1_valid, req1_funsel, req1_a, req1_b, req1_use_carry,
      output alu_out, alu_flags,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
      input  alu_a, alu_b, alu_funsel, alu_cin
   );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one registered ALU between two requesters, with a
// private carry bit per requester for carry chains.
module alu_scheduler #(
   parameter int unsigned FLAG_LATENCY = 3
) (
   input  logic           clock,
   input  logic           reset_n,
   alu_scheduler_if.slave bus,
   output logic           busy
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned FUN_W  = 5;
   localparam int unsigned CNT_W  = $clog2(FLAG_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic              rr_ptr;
   logic              port_q;
   logic [1:0]        carry_q;
   logic [CNT_W-1:0]  cnt;

   logic              grant_c;
   logic              accept_c;
   logic              sel_use_carry_c;
   logic [FUN_W-1:0]  sel_funsel_c;
   logic [DATA_W-1:0] sel_a_c;
   logic [DATA_W-1:0] sel_b_c;

   // Grant: a lone requester wins; on contention the port not served last wins
   always_comb begin
      grant_c         = bus.req1_valid & (~bus.req0_valid | rr_ptr);
      sel_funsel_c    = grant_c ? bus.req1_funsel    : bus.req0_funsel;
      sel_a_c         = grant_c ? bus.req1_a         : bus.req0_a;
      sel_b_c         = grant_c ? bus.req1_b         : bus.req0_b;
      sel_use_carry_c = grant_c ? bus.req1_use_carry : bus.req0_use_carry;
      accept_c        = (state == IDLE) & (grant_c ? bus.req1_valid : bus.req0_valid);
   end

   assign bus.req0_ready = (state == IDLE) & ~grant_c;
   assign bus.req1_ready = (state == IDLE) &  grant_c;

   // Sequencer: latch operands, hold them through the ALU pipeline, capture, respond
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         rr_ptr         <= 1'b0;
         port_q         <= 1'b0;
         carry_q        <= 2'b00;
         cnt            <= '0;
         busy           <= 1'b0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_funsel <= '0;
         bus.alu_cin    <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_flags  <= '0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
      end else begin
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  bus.alu_funsel <= sel_funsel_c;
                  bus.alu_a      <= sel_a_c;
                  bus.alu_b      <= sel_b_c;
                  bus.alu_cin    <= sel_use_carry_c & carry_q[grant_c];
                  port_q         <= grant_c;
                  rr_ptr         <= ~grant_c;
                  cnt            <= CNT_W'(FLAG_LATENCY);
                  busy           <= 1'b1;
                  state          <= HOLD;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  bus.rsp_result  <= bus.alu_out;
                  bus.rsp_flags   <= bus.alu_flags;
                  carry_q[port_q] <= bus.alu_flags[2];
                  bus.rsp0_valid  <= ~port_q;
                  bus.rsp1_valid  <= port_q;
                  state           <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: two DUTs (FLAG_LATENCY 3 and 1), each
// driving a small registered ALU model.
module tb_alu_scheduler;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic busy_a;
   logic busy_b;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clock = ~clock;

   alu_scheduler_if ifa ();
   alu_scheduler_if ifb ();

   alu_scheduler #(.FLAG_LATENCY(3)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .bus(ifa.slave), .busy(busy_a));
   alu_scheduler #(.FLAG_LATENCY(1)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .bus(ifb.slave), .busy(busy_b));

   // ALU reference: returns {Z,C,N,V,result}
   function automatic logic [35:0] alu_fn(input logic [4:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
      logic [32:0] s;
      logic [31:0] r;
      logic [15:0] d;
      logic c;
      logic v;
      c = cin;
      v = 1'b0;
      s = '0;
      d = '0;
      case (fs)
         5'b10100: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b10101: begin
            s = {1'b0, a} + {1'b0, b} + 33'(cin);
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'b00110: begin
            d = a[15:0] - b[15:0];
            r = {{16{d[15]}}, d};
         end
         default: r = a & b;
      endcase
      return {(r == 32'd0), c, r[31], v, r};
   endfunction

   logic [35:0] pa [0:2] = '{36'd0, 36'd0, 36'd0};
   logic [35:0] pb [0:0] = '{36'd0};

   always @(posedge clock) begin
      pa[0] <= alu_fn(ifa.alu_funsel, ifa.alu_a, ifa.alu_b, ifa.alu_cin);
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pb[0] <= alu_fn(ifb.alu_funsel, ifb.alu_a, ifb.alu_b, ifb.alu_cin);
   end
   assign ifa.alu_out   = pa[2][31:0];
   assign ifa.alu_flags = pa[2][35:32];
   assign ifb.alu_out   = pb[0][31:0];
   assign ifb.alu_flags = pb[0][35:32];

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Issue one request on DUT A and observe it until its response pulse
   task automatic do_op(input bit port, input logic [4:0] fs, input logic [31:0] a,
                        input logic [31:0] b, input bit uc, output int lat,
                        output logic [31:0] res, output logic [3:0] flg,
                        output logic cin_seen, output bit stable, output bit width_ok,
                        output bit other);
      bit got;
      lat = -1; res = '0; flg = '0; cin_seen = 1'b0;
      stable = 1'b1; width_ok = 1'b0; other = 1'b0; got = 1'b0;
      @(negedge clock);
      if (!port) begin
         ifa.req0_funsel = fs; ifa.req0_a = a; ifa.req0_b = b;
         ifa.req0_use_carry = uc; ifa.req0_valid = 1'b1;
      end else begin
         ifa.req1_funsel = fs; ifa.req1_a = a; ifa.req1_b = b;
         ifa.req1_use_carry = uc; ifa.req1_valid = 1'b1;
      end
      for (int w = 0; w < 20; w++) begin
         #1;
         if (port ? ifa.req1_ready : ifa.req0_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!got) begin
         ifa.req0_valid = 1'b0;
         ifa.req1_valid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      if (!port) ifa.req0_valid = 1'b0;
      else       ifa.req1_valid = 1'b0;
      cin_seen = ifa.alu_cin;
      for (int k = 1; k <= 12; k++) begin
         if (port ? ifa.rsp0_valid : ifa.rsp1_valid) other = 1'b1;
         if (port ? ifa.rsp1_valid : ifa.rsp0_valid) begin
            lat = k;
            res = ifa.rsp_result;
            flg = ifa.rsp_flags;
            @(negedge clock);
            width_ok = !(port ? ifa.rsp1_valid : ifa.rsp0_valid);
            if (port ? ifa.rsp0_valid : ifa.rsp1_valid) other = 1'b1;
            break;
         end
         if (ifa.alu_a !== a || ifa.alu_b !== b || ifa.alu_funsel !== fs ||
             ifa.alu_cin !== cin_seen) stable = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else n_pass++;
      n_checks++; if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", {ifa.rsp0_valid, ifa.rsp1_valid}); else n_pass++;
      n_checks++; if (ifa.rsp_result !== 32'd0) $display("FAIL reset_rsp_result: got %h expected 0", ifa.rsp_result); else n_pass++;
      n_checks++; if (ifa.rsp_flags !== 4'd0) $display("FAIL reset_rsp_flags: got %b expected 0000", ifa.rsp_flags); else n_pass++;
      n_checks++; if ({ifa.alu_a, ifa.alu_b} !== 64'd0) $display("FAIL reset_alu_ab: got %h expected 0", {ifa.alu_a, ifa.alu_b}); else n_pass++;
      n_checks++; if ({ifa.alu_funsel, ifa.alu_cin} !== 6'd0) $display("FAIL reset_alu_fs_cin: got %b expected 000000", {ifa.alu_funsel, ifa.alu_cin}); else n_pass++;
      n_checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) $display("FAIL reset_ready: got %b expected 10", {ifa.req0_ready, ifa.req1_ready}); else n_pass++;
   endtask

   task automatic test_port0_only();
      int lat; logic [31:0] res; logic [3:0] flg; logic cin; bit st, wok, oth;
      do_op(1'b0, 5'b10100, 32'h5, 32'h3, 1'b0, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (lat !== 5) $display("FAIL p0_latency: got %0d expected 5", lat); else n_pass++;
      n_checks++; if (res !== 32'h8) $display("FAIL p0_result: got %h expected 00000008", res); else n_pass++;
      n_checks++; if (flg !== 4'b0000) $display("FAIL p0_flags: got %b expected 0000", flg); else n_pass++;
      n_checks++; if (st !== 1'b1) $display("FAIL p0_alu_stable: got %b expected 1", st); else n_pass++;
      n_checks++; if (wok !== 1'b1) $display("FAIL p0_pulse_width: got %b expected 1", wok); else n_pass++;
      n_checks++; if (oth !== 1'b0) $display("FAIL p0_rsp1_quiet: got %b expected 0", oth); else n_pass++;
      #1;
      n_checks++; if ({busy_a, ifa.req0_ready} !== 2'b01) $display("FAIL p0_back_idle: got %b expected 01", {busy_a, ifa.req0_ready}); else n_pass++;
      n_checks++; if (ifa.alu_a !== 32'h5) $display("FAIL p0_alu_hold_idle: got %h expected 00000005", ifa.alu_a); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int g_port [4]; int g_cyc [4]; int r_port [4]; logic [31:0] r_res [4];
      int ng; int nr;
      ng = 0; nr = 0;
      apply_reset();
      ifa.req0_funsel = 5'b10100; ifa.req0_a = 32'd1;  ifa.req0_b = 32'd1;  ifa.req0_use_carry = 1'b0;
      ifa.req1_funsel = 5'b10100; ifa.req1_a = 32'd10; ifa.req1_b = 32'd20; ifa.req1_use_carry = 1'b0;
      ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (ng == 4 && (ifa.req0_valid || ifa.req1_valid)) begin
            ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0; #1;
         end
         if (nr < 4 && ifa.rsp0_valid) begin r_port[nr] = 0; r_res[nr] = ifa.rsp_result; nr++; end
         else if (nr < 4 && ifa.rsp1_valid) begin r_port[nr] = 1; r_res[nr] = ifa.rsp_result; nr++; end
         if (ng < 4 && ifa.req0_valid && ifa.req0_ready) begin g_port[ng] = 0; g_cyc[ng] = c; ng++; end
         else if (ng < 4 && ifa.req1_valid && ifa.req1_ready) begin g_port[ng] = 1; g_cyc[ng] = c; ng++; end
         @(negedge clock);
      end
      ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
      n_checks++; if (ng !== 4) $display("FAIL b2b_grant_count: got %0d expected 4", ng); else n_pass++;
      n_checks++; if (nr !== 4) $display("FAIL b2b_rsp_count: got %0d expected 4", nr); else n_pass++;
      if (ng == 4 && nr == 4) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (g_port[i] !== i % 2) $display("FAIL b2b_grant_%0d: got port %0d expected %0d", i, g_port[i], i % 2); else n_pass++;
            n_checks++; if (r_port[i] !== i % 2) $display("FAIL b2b_rsp_%0d: got port %0d expected %0d", i, r_port[i], i % 2); else n_pass++;
         end
         for (int i = 0; i < 3; i++) begin
            n_checks++; if (g_cyc[i+1] - g_cyc[i] !== 6) $display("FAIL b2b_spacing_%0d: got %0d expected 6", i, g_cyc[i+1] - g_cyc[i]); else n_pass++;
         end
         n_checks++; if (r_res[0] !== 32'd2) $display("FAIL b2b_res0: got %h expected 00000002", r_res[0]); else n_pass++;
         n_checks++; if (r_res[1] !== 32'd30) $display("FAIL b2b_res1: got %h expected 0000001e", r_res[1]); else n_pass++;
      end
   endtask

   task automatic test_carry_chain();
      int lat; logic [31:0] res; logic [3:0] flg; logic cin; bit st, wok, oth;
      do_op(1'b0, 5'b10100, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (res !== 32'h0) $display("FAIL cc_op1_result: got %h expected 00000000", res); else n_pass++;
      n_checks++; if (flg !== 4'b1100) $display("FAIL cc_op1_flags: got %b expected 1100", flg); else n_pass++;
      do_op(1'b1, 5'b10101, 32'h0, 32'h0, 1'b1, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (cin !== 1'b0) $display("FAIL cc_p1_cin: got %b expected 0", cin); else n_pass++;
      n_checks++; if (res !== 32'h0) $display("FAIL cc_p1_result: got %h expected 00000000", res); else n_pass++;
      do_op(1'b0, 5'b10101, 32'h0, 32'h0, 1'b1, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (cin !== 1'b1) $display("FAIL cc_op2_cin: got %b expected 1", cin); else n_pass++;
      n_checks++; if (res !== 32'h1) $display("FAIL cc_op2_result: got %h expected 00000001", res); else n_pass++;
      n_checks++; if (st !== 1'b1) $display("FAIL cc_op2_stable: got %b expected 1", st); else n_pass++;
   endtask

   task automatic test_held_payload();
      bit stable; bit acc; bit got0; bit got1; logic [31:0] res0; logic [31:0] acc_a;
      stable = 1'b1; acc = 1'b0; got0 = 1'b0; got1 = 1'b0; res0 = '0; acc_a = '0;
      @(negedge clock);
      ifa.req0_funsel = 5'b10100; ifa.req0_a = 32'd7; ifa.req0_b = 32'd8;
      ifa.req0_use_carry = 1'b0; ifa.req0_valid = 1'b1;
      #1;
      n_checks++; if (ifa.req0_ready !== 1'b1) $display("FAIL hp_p0_ready: got %b expected 1", ifa.req0_ready); else n_pass++;
      @(posedge clock);
      @(negedge clock);
      ifa.req0_valid = 1'b0;
      ifa.req1_funsel = 5'b10100; ifa.req1_b = 32'd1; ifa.req1_use_carry = 1'b0; ifa.req1_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         ifa.req1_a = 32'h200 + 32'(k);
         #1;
         if (ifa.rsp0_valid) begin got0 = 1'b1; res0 = ifa.rsp_result; end
         if (ifa.req1_ready) begin acc = 1'b1; acc_a = ifa.req1_a; break; end
         if (ifa.alu_a !== 32'd7 || ifa.alu_b !== 32'd8 || ifa.alu_funsel !== 5'b10100) stable = 1'b0;
         @(negedge clock);
      end
      n_checks++; if (acc !== 1'b1) $display("FAIL hp_p1_accepted: got %b expected 1", acc); else n_pass++;
      n_checks++; if (stable !== 1'b1) $display("FAIL hp_alu_stable: got %b expected 1", stable); else n_pass++;
      n_checks++; if ({got0, res0} !== {1'b1, 32'd15}) $display("FAIL hp_p0_rsp: got %b/%h expected 1/0000000f", got0, res0); else n_pass++;
      n_checks++; if (acc_a !== 32'h205) $display("FAIL hp_sampled_a: got %h expected 00000205", acc_a); else n_pass++;
      @(posedge clock);
      @(negedge clock);
      ifa.req1_valid = 1'b0;
      ifa.req1_a = 32'hDEAD_BEEF;
      #1;
      n_checks++; if ({ifa.alu_a, ifa.alu_b} !== {32'h205, 32'h1}) $display("FAIL hp_alu_latched: got %h expected 0000020500000001", {ifa.alu_a, ifa.alu_b}); else n_pass++;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (ifa.rsp1_valid) begin
            got1 = 1'b1;
            n_checks++; if (ifa.rsp_result !== 32'h206) $display("FAIL hp_p1_result: got %h expected 00000206", ifa.rsp_result); else n_pass++;
            n_checks++; if (ifa.alu_a !== 32'h205) $display("FAIL hp_alu_held: got %h expected 00000205", ifa.alu_a); else n_pass++;
            break;
         end
      end
      n_checks++; if (got1 !== 1'b1) $display("FAIL hp_p1_rsp_seen: got %b expected 1", got1); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [31:0] res; logic [3:0] flg; logic cin; bit st, wok, oth; bit pulse;
      pulse = 1'b0;
      do_op(1'b0, 5'b10100, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (flg[2] !== 1'b1) $display("FAIL rm_carry_set: got %b expected 1", flg[2]); else n_pass++;
      @(negedge clock);
      ifa.req0_funsel = 5'b10100; ifa.req0_a = 32'd2; ifa.req0_b = 32'd3;
      ifa.req0_use_carry = 1'b0; ifa.req0_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      ifa.req0_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 2) reset_n = 1'b1;
         #1;
         if (ifa.rsp0_valid || ifa.rsp1_valid) pulse = 1'b1;
         @(negedge clock);
      end
      #1;
      n_checks++; if (pulse !== 1'b0) $display("FAIL rm_no_rsp: got %b expected 0", pulse); else n_pass++;
      n_checks++; if ({busy_a, ifa.req0_ready} !== 2'b01) $display("FAIL rm_idle: got %b expected 01", {busy_a, ifa.req0_ready}); else n_pass++;
      n_checks++; if (ifa.alu_a !== 32'd0) $display("FAIL rm_alu_a_cleared: got %h expected 00000000", ifa.alu_a); else n_pass++;
      do_op(1'b0, 5'b10101, 32'h0, 32'h0, 1'b1, lat, res, flg, cin, st, wok, oth);
      n_checks++; if (cin !== 1'b0) $display("FAIL rm_carry_cleared: got %b expected 0", cin); else n_pass++;
      n_checks++; if (lat !== 5) $display("FAIL rm_next_latency: got %0d expected 5", lat); else n_pass++;
      n_checks++; if (res !== 32'h0) $display("FAIL rm_next_result: got %h expected 00000000", res); else n_pass++;
   endtask

   task automatic test_latency1();
      int lat;
      lat = -1;
      @(negedge clock);
      ifb.req0_funsel = 5'b00110; ifb.req0_a = 32'h5; ifb.req0_b = 32'h7;
      ifb.req0_use_carry = 1'b0; ifb.req0_valid = 1'b1;
      #1;
      n_checks++; if (ifb.req0_ready !== 1'b1) $display("FAIL l1_ready: got %b expected 1", ifb.req0_ready); else n_pass++;
      @(posedge clock);
      @(negedge clock);
      ifb.req0_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (ifb.rsp0_valid) begin
            lat = k;
            n_checks++; if (ifb.rsp_result !== 32'hFFFF_FFFE) $display("FAIL l1_result: got %h expected fffffffe", ifb.rsp_result); else n_pass++;
            break;
         end
         @(negedge clock);
      end
      n_checks++; if (lat !== 3) $display("FAIL l1_latency: got %0d expected 3", lat); else n_pass++;
   endtask

   initial begin
      ifa.req0_valid = 1'b0; ifa.req0_funsel = '0; ifa.req0_a = '0; ifa.req0_b = '0; ifa.req0_use_carry = 1'b0;
      ifa.req1_valid = 1'b0; ifa.req1_funsel = '0; ifa.req1_a = '0; ifa.req1_b = '0; ifa.req1_use_carry = 1'b0;
      ifb.req0_valid = 1'b0; ifb.req0_funsel = '0; ifb.req0_a = '0; ifb.req0_b = '0; ifb.req0_use_carry = 1'b0;
      ifb.req1_valid = 1'b0; ifb.req1_funsel = '0; ifb.req1_a = '0; ifb.req1_b = '0; ifb.req1_use_carry = 1'b0;
      test_reset();
      test_port0_only();
      test_back_to_back();
      test_carry_chain();
      test_held_payload();
      test_reset_mid_op();
      test_latency1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares one 32-bit ALU instance (5-bit FunSel, registered ALUOut, flags Z|C|N|V) between two requesters, e.g. the instruction sequencer (port 0) and the address/offset unit (port 1).
- Arbitrates round-robin and holds operands stable for the ALU's registered pipeline.
- Captures the result and flags, and returns them with a one-cycle response pulse.
- Keeps a carry bit per requester, so each requester can run its own add-with-carry / rotate-through-carry chain.

Parameters:
- FLAG_LATENCY, 3: rising edges from operands driven on alu_* until alu_flags reflects that operation. Must be ≥ 1.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
req0_valid  in  1  port 0 request; payload held stable until accepted
req0_ready  out  1  port 0 accept; transfer on req0_valid & req0_ready at rising edge
req0_funsel  in  5  ALU function select for port 0
req0_a  in  32  operand A for port 0
req0_b  in  32  operand B for port 0
req0_use_carry  in  1  1 = drive ALU cin from port 0 carry register; 0 = cin 0
req1_valid, req1_ready, req1_funsel, req1_a, req1_b, req1_use_carry  same as port 0, for port 1
rsp0_valid  out  1  one-cycle pulse: response for port 0
rsp1_valid  out  1  one-cycle pulse: response for port 1
rsp_result  out  32  captured ALU result, valid while either rsp*_valid is high
rsp_flags  out  4  captured {Z,C,N,V}, valid with rsp_result
alu_a  out  32  to ALU input_a
alu_b  out  32  to ALU input_b
alu_funsel  out  5  to ALU FunSel
alu_cin  out  1  to ALU cin
alu_out  in  32  from ALU ALUOut
alu_flags  in  4  from ALU flags
busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- Reset is synchronous and active-low (reset_n=0 sampled at a clock edge).
- Reset values: state=IDLE; rr pointer=port 0 preferred; both carry registers=0; alu_a/alu_b=0; alu_funsel=5'b00000; alu_cin=0; rsp_result=0; rsp_flags=0; rsp0_valid/rsp1_valid=0; busy=0.
- Reset mid-operation aborts the operation: no response is issued and carry registers are cleared.

States: IDLE, HOLD, RESP.

IDLE:
- reqN_ready is combinational and high only in IDLE, for exactly one port.
- Only one valid request: that port is granted.
- Both valid: the port that was not granted last is granted.
- On acceptance edge T:
  - latch funsel, a, b and the granted port id.
  - latch cin = use_carry ? carry_reg[port] : 0.
  - the rr pointer moves to the other port.
  - load the counter with FLAG_LATENCY; go to HOLD.

HOLD:
- alu_* are driven from the latched registers and do not change for the whole of HOLD.
- The counter decrements each cycle.
- At edge T+FLAG_LATENCY+1 (counter reaches 0):
  - rsp_result <= alu_out; rsp_flags <= alu_flags.
  - carry_reg[port] <= alu_flags[2].
  - go to RESP.

RESP:
- Exactly one of rsp0_valid/rsp1_valid is high for one cycle; go to IDLE at the next edge.
- reqN_ready is low in RESP.

Latency and throughput:
- The response pulse is visible in the cycle after edge T+FLAG_LATENCY+1.
- The earliest next acceptance is edge T+FLAG_LATENCY+3, i.e. 6 cycles per operation at default.

Output holding and ports:
- alu_* keep their last driven value in IDLE and RESP; they are not zeroed.
- rsp_result/rsp_flags hold their value until the next capture.
- A request on a port that is not granted waits with ready low; no request is dropped.
- A port can never be granted twice in a row while the other port is valid (no starvation).

Carry registers:
- Carry registers update on every capture, including non-carry ops; the ALU passes cin through as C for those ops.
- Carry registers are independent per port. A port-1 operation never alters the port-0 carry.

Test Plan:
1. Port 0 only: funsel 10100, a=0x0000_0005, b=0x0000_0003 → alu_* stable for 4 edges; rsp0_valid 1 cycle; rsp_result=0x8; rsp_flags=4'b0000; rsp1_valid stays 0.
2. Both valid in the same cycle after reset, repeated back-to-back → grants alternate 0,1,0,1; responses follow in the same order; each operation takes 6 cycles.
3. Port 0 carry chain:
   - Op 1: funsel 10100, a=0xFFFF_FFFF, b=0x1 → rsp_flags C=1, rsp_result=0.
   - Op 2: 10101 with use_carry=1, a=0, b=0 → alu_cin=1, rsp_result=1.
   - A port-1 op using use_carry=1 between the two sees alu_cin=0.
4. Port 1 holds req1_valid with changing payload while port 0 is busy → payload is sampled only on the acceptance edge; no change is visible on alu_* during HOLD.
5. Assert reset_n=0 during HOLD, then release → no rsp*_valid pulse; state IDLE; carry registers 0; next request is serviced normally.
6. FLAG_LATENCY=1 build, 16-bit op 00110 with a=0x0005, b=0x0007 → response 3 cycles after acceptance; rsp_result=0xFFFF_FFFE.
